// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: light codes, state
// encoding, service-direction constants and the state-to-head decode.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        WALK      = 3'd6
    } ctrl_state_t;

    // Any state that is not an NS service state shows red on the NS head.
    function automatic logic [1:0] ns_light_of(input ctrl_state_t s);
        case (s)
            NS_GREEN:  return LIGHT_GREEN;
            NS_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    function automatic logic [1:0] ew_light_of(input ctrl_state_t s);
        case (s)
            EW_GREEN:  return LIGHT_GREEN;
            EW_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state cycle counter: clears on a state change, otherwise counts up,
// and holds at sat_lim while sat_en is high (used to park a resting green).
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sat_en,
    input  logic [CNT_W-1:0] sat_lim,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, then saturation, then increment.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr) begin
            cnt_d = '0;
        end else if (sat_en && (cnt_q >= sat_lim)) begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection phase scheduler with pedestrian walk phase.
//
// state     | meaning
// ----------+--------------------------------------------------
// NS_GREEN  | NS green; rests here until EW car or ped demand
// NS_YELLOW | NS yellow, fixed duration
// ALL_RED_A | clearance after NS; picks WALK or EW_GREEN
// EW_GREEN  | EW green; rests here until NS car or ped demand
// EW_YELLOW | EW yellow, fixed duration
// ALL_RED_B | clearance after EW; picks WALK or NS_GREEN
// WALK      | both heads red, walk lamp on; then green of next_dir
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALL_RED_T = 1,
    parameter int WALK_T    = 5,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic       phase_start,
    output logic [2:0] state_dbg
);

    if (MIN_GREEN < 1) begin : g_bad_min_green
        $error("MIN_GREEN must be at least 1");
    end
    if (MAX_GREEN < MIN_GREEN) begin : g_bad_max_green
        $error("MAX_GREEN must not be below MIN_GREEN");
    end
    if (YELLOW_T < 1 || ALL_RED_T < 1 || WALK_T < 1) begin : g_bad_fixed
        $error("YELLOW_T, ALL_RED_T and WALK_T must be at least 1");
    end
    if (CNT_W < 1 || CNT_W > 31 || MAX_GREEN > (1 << CNT_W) || YELLOW_T > (1 << CNT_W)
        || ALL_RED_T > (1 << CNT_W) || WALK_T > (1 << CNT_W)) begin : g_bad_width
        $error("a duration does not fit in CNT_W bits");
    end

    // Last timer value of each interval: the exit edge is where timer hits it.
    localparam logic [CNT_W-1:0] MIN_G_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_G_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_T - 1);

    ctrl_state_t      state_q, state_d;
    logic             next_dir_q, next_dir_d;
    logic             ped_pending_q, ped_pending_d;
    logic [1:0]       ns_light_q, ns_light_d;
    logic [1:0]       ew_light_q, ew_light_d;
    logic             walk_q, walk_d;
    logic             phase_start_q, phase_start_d;
    logic [CNT_W-1:0] timer;
    logic             state_change;
    logic             in_green;

    assign state_change = (state_d != state_q);
    assign in_green     = (state_q == NS_GREEN) || (state_q == EW_GREEN);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_change),
        .sat_en  (in_green),
        .sat_lim (MAX_G_LAST),
        .cnt     (timer)
    );

    // Next state, service direction, pedestrian latch and output decode.
    // Outputs are decoded from state_d so the registered heads always match
    // the registered state.
    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            NS_GREEN: begin
                if (timer >= MIN_G_LAST && (ew_car || ped_pending_q)
                    && (!ns_car || timer == MAX_G_LAST)) begin
                    state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: if (timer == YEL_LAST) state_d = ALL_RED_A;
            ALL_RED_A: begin
                if (timer == RED_LAST) begin
                    state_d    = ped_pending_q ? WALK : EW_GREEN;
                    next_dir_d = DIR_EW;
                end
            end
            EW_GREEN: begin
                if (timer >= MIN_G_LAST && (ns_car || ped_pending_q)
                    && (!ew_car || timer == MAX_G_LAST)) begin
                    state_d = EW_YELLOW;
                end
            end
            EW_YELLOW: if (timer == YEL_LAST) state_d = ALL_RED_B;
            ALL_RED_B: begin
                if (timer == RED_LAST) begin
                    state_d    = ped_pending_q ? WALK : NS_GREEN;
                    next_dir_d = DIR_NS;
                end
            end
            WALK: begin
                if (timer == WALK_LAST) begin
                    state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
                end
            end
            default: state_d = NS_GREEN;
        endcase

        // Entering WALK serves the request; a press on that same edge is absorbed.
        if (state_d == WALK && state_q != WALK) begin
            ped_pending_d = 1'b0;
        end else begin
            ped_pending_d = ped_pending_q | ped_req;
        end

        ns_light_d    = ns_light_of(state_d);
        ew_light_d    = ew_light_of(state_d);
        walk_d        = (state_d == WALK);
        phase_start_d = state_change;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NS_GREEN;
            next_dir_q    <= DIR_EW;
            ped_pending_q <= 1'b0;
            ns_light_q    <= LIGHT_GREEN;
            ew_light_q    <= LIGHT_RED;
            walk_q        <= 1'b0;
            phase_start_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
            ns_light_q    <= ns_light_d;
            ew_light_q    <= ew_light_d;
            walk_q        <= walk_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign ns_light    = ns_light_q;
    assign ew_light    = ew_light_q;
    assign walk        = walk_q;
    assign ped_pending = ped_pending_q;
    assign phase_start = phase_start_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl. Expected per-cycle outputs are
// queued as stimulus is applied and popped when the cycle is observed.
module tb_traffic_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic       ped_pending;
    logic       phase_start;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    traffic_intersection_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ns_car      (ns_car),
        .ew_car      (ew_car),
        .ped_req     (ped_req),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase_start (phase_start),
        .state_dbg   (state_dbg)
    );

    typedef struct packed {
        logic [1:0] ns;
        logic [1:0] ew;
        logic       wlk;
        logic       ped;
        logic       ps;
        logic [2:0] st;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic obs_t mk(input int st, input bit ped, input bit ps);
        obs_t o;
        o.ns  = (st == 0) ? 2'b10 : (st == 1) ? 2'b01 : 2'b00;
        o.ew  = (st == 3) ? 2'b10 : (st == 4) ? 2'b01 : 2'b00;
        o.wlk = (st == 6);
        o.ped = ped;
        o.ps  = ps;
        o.st  = 3'(st);
        return o;
    endfunction

    task automatic expect_cyc(input string tag, input int st, input bit ped, input bit ps);
        exp_q.push_back(mk(st, ped, ps));
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        obs_t  got;
        obs_t  exp;
        string tag;
        logic  safe;
        got  = {ns_light, ew_light, walk, ped_pending, phase_start, state_dbg};
        safe = (ns_light == 2'b00) || (ew_light == 2'b00);
        vectors++;
        assert (safe === 1'b1) else begin
            miscompares++;
            $error("FAIL both_nonred: observed ns=%b ew=%b expected one head red", ns_light, ew_light);
        end
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h expected a queued entry", got);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            vectors++;
            assert (got === exp) else begin
                miscompares++;
                $error("FAIL %s: observed ns=%b ew=%b walk=%b ped=%b ps=%b st=%0d expected ns=%b ew=%b walk=%b ped=%b ps=%b st=%0d",
                       tag, got.ns, got.ew, got.wlk, got.ped, got.ps, got.st,
                       exp.ns, exp.ew, exp.wlk, exp.ped, exp.ps, exp.st);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    // Leaves the bench at cycle 0 (first cycle after rst deasserts), checked.
    task automatic do_reset(input string tag);
        rst     = 1'b1;
        ns_car  = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_cyc(tag, 0, 1'b0, 1'b1);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached expected $finish");
        $fatal(1, "time limit");
    end

    initial begin
        int c;
        int m;
        int st;
        bit ped;
        bit ps;

        // EW car only: NS green 0-3, yellow 4-5, all-red 6, EW green from 7.
        do_reset("t1_c0");
        for (int k = 0; k < 14; k++) begin
            ew_car = 1'b1;
            c  = k + 1;
            st = (c <= 3) ? 0 : (c <= 5) ? 1 : (c == 6) ? 2 : 3;
            ps = (c == 4) || (c == 6) || (c == 7);
            expect_cyc($sformatf("t1_c%0d", c), st, 1'b0, ps);
            tick();
        end

        // Both approaches busy: MAX_GREEN on each side, period 26.
        do_reset("t2_c0");
        for (int k = 0; k < 60; k++) begin
            ns_car = 1'b1;
            ew_car = 1'b1;
            c  = k + 1;
            m  = c % 26;
            st = (m < 10) ? 0 : (m < 12) ? 1 : (m == 12) ? 2 : (m < 23) ? 3 : (m < 25) ? 4 : 5;
            ps = (m == 0) || (m == 10) || (m == 12) || (m == 13) || (m == 23) || (m == 25);
            expect_cyc($sformatf("t2_c%0d", c), st, 1'b0, ps);
            tick();
        end

        // Idle: NS green rests; timer parked at MAX_GREEN-1, so demand with
        // ns_car still present exits on the very next edge.
        do_reset("t3_c0");
        for (int k = 0; k < 50; k++) begin
            c = k + 1;
            expect_cyc($sformatf("t3_c%0d", c), 0, 1'b0, 1'b0);
            tick();
        end
        ns_car = 1'b1;
        ew_car = 1'b1;
        expect_cyc("t3_sat_exit", 1, 1'b0, 1'b1);
        tick();

        // Ped pulse at cycle 2, no cars: WALK 7-11, then EW green at 12.
        do_reset("t4_c0");
        for (int k = 0; k < 14; k++) begin
            ped_req = (k == 2);
            c   = k + 1;
            st  = (c <= 3) ? 0 : (c <= 5) ? 1 : (c == 6) ? 2 : (c <= 11) ? 6 : 3;
            ped = (c >= 3) && (c <= 6);
            ps  = (c == 4) || (c == 6) || (c == 7) || (c == 12);
            expect_cyc($sformatf("t4_c%0d", c), st, ped, ps);
            tick();
        end

        // Press on the WALK-entry edge is absorbed; press in 3rd walk cycle
        // re-arms, giving a second WALK after ALL_RED_B, then NS green.
        do_reset("t5_c0");
        for (int k = 0; k < 27; k++) begin
            ped_req = (k == 2) || (k == 6) || (k == 9);
            c  = k + 1;
            st = (c <= 3) ? 0 : (c <= 5) ? 1 : (c == 6) ? 2 : (c <= 11) ? 6 :
                 (c <= 15) ? 3 : (c <= 17) ? 4 : (c == 18) ? 5 : (c <= 23) ? 6 : 0;
            ped = ((c >= 3) && (c <= 6)) || ((c >= 10) && (c <= 18));
            ps  = (c == 4) || (c == 6) || (c == 7) || (c == 12) || (c == 16) ||
                  (c == 18) || (c == 19) || (c == 24);
            expect_cyc($sformatf("t5_c%0d", c), st, ped, ps);
            tick();
        end
        ped_req = 1'b0;

        // Reset during EW yellow with a request pending: straight to NS green.
        do_reset("t6_c0");
        for (int k = 0; k < 13; k++) begin
            ew_car  = (k < 7);
            ns_car  = (k >= 7);
            ped_req = (k == 11);
            rst     = (k == 12);
            c   = k + 1;
            st  = (c <= 3) ? 0 : (c <= 5) ? 1 : (c == 6) ? 2 : (c <= 10) ? 3 : (c <= 12) ? 4 : 0;
            ped = (c == 12);
            ps  = (c == 4) || (c == 6) || (c == 7) || (c == 11) || (c == 13);
            expect_cyc($sformatf("t6_c%0d", c), st, ped, ps);
            tick();
        end
        rst     = 1'b0;
        ns_car  = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        expect_cyc("t6_after_rst", 0, 1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
